dmem_bus_arbiter: RTL and testbench
===================================

Name: dmem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the data-memory bus.
- Master 0 is the core MEM-stage port, driven by the atomic access controller. Master 1 is a secondary requester (debug/DMA).
- Round-robin grants, with a lock that keeps the bus owned across AMO read-modify-write sequences.
- Reports Master-1 writes that hit the core's LR reservation, so a later SC fails.

Parameters:
- LOCK_TIMEOUT, 16: max cycles a locked owner may hold the bus idle (no req) before forced release; 0 disables the timeout.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- m0_req  in  1  master 0 transfer request, held until m0_ack
- m0_we  in  1  master 0 write enable
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_sel  in  4  master 0 byte enables
- m0_lock  in  1  master 0 keep bus after this transfer (AMO in progress)
- m0_rdata  out  DATA_W  master 0 read data
- m0_ack  out  1  master 0 transfer complete
- m1_req, m1_we, m1_addr, m1_wdata, m1_sel, m1_lock, m1_rdata, m1_ack: same as m0_*, for master 1
- s_req  out  1  slave request
- s_we  out  1  slave write enable
- s_addr  out  ADDR_W  slave address
- s_wdata  out  DATA_W  slave write data
- s_sel  out  4  slave byte enables
- s_rdata  in  DATA_W  slave read data
- s_ack  in  1  slave completion, single-cycle pulse
- resv_valid  in  1  core LR reservation active
- resv_addr  in  ADDR_W  reserved address
- resv_kill  out  1  one-cycle pulse: master 1 wrote the reserved word
- grant  out  2  one-hot current owner (debug/perf)

Reset:
- rst is asynchronous, active-high; clock is clk.
- On reset: state=IDLE, last_grant=1 (so master 0 wins the first tie), lock counter=0.
- All outputs 0: s_req, s_we, s_addr, s_wdata, s_sel, m0_ack, m1_ack, m0_rdata, m1_rdata, resv_kill, grant.

Behaviour:
- States: IDLE, OWN0, OWN1, LOCKED0, LOCKED1. The state register is the only grant source.
- IDLE:
  - No slave outputs driven (all 0).
  - Only m0_req: next OWN0. Only m1_req: next OWN1.
  - Both: grant the master other than last_grant.
  - Arbitration costs 1 cycle: request seen at cycle N, s_req high at N+1.
- OWNx:
  - s_* muxed combinationally from master x. s_rdata is routed to mx_rdata; mx_ack = s_ack.
  - The other master's ack is 0 and its rdata holds 0.
  - On s_ack: last_grant<=x.
    - If mx_lock=1 at the ack cycle: next LOCKEDx, counter cleared.
    - Else: next IDLE, so there is at least one idle bus cycle between unlocked transfers.
  - If mx_req drops before ack (protocol violation): return to IDLE; the slave must tolerate an aborted request.
- LOCKEDx:
  - Bus stays with x. s_req=mx_req, muxed exactly as in OWNx.
  - Other master is blocked regardless of its req.
  - mx_req=1: transfer proceeds with zero arbitration cycles and the counter clears. On its ack: lock=1 stays in LOCKEDx; lock=0 goes to IDLE.
  - mx_req=0 and mx_lock=0: next IDLE.
  - mx_req=0 and mx_lock=1: counter increments. At counter==LOCK_TIMEOUT-1 (LOCK_TIMEOUT≠0), forced next IDLE and last_grant<=x, so the other master wins if it is waiting.
- Reservation snoop:
  - resv_kill<=1 for one cycle, the cycle after the ack cycle, when all hold in the ack cycle: state OWN1 or LOCKED1, s_ack=1, s_we=1, resv_valid=1, s_addr[ADDR_W-1:2]==resv_addr[ADDR_W-1:2].
  - The word compare applies regardless of m1_sel.
  - Master-0 writes never raise resv_kill.
- Simultaneous events:
  - s_ack in the same cycle the other master raises req: the ack completes; the other master is arbitered from IDLE next.
  - resv_kill and a new grant may coincide.
- Reset mid-transfer: bus outputs drop to 0 immediately (async); any lock is lost; the in-flight transfer is discarded with no ack.
- Width rules: the lock counter is clog2(LOCK_TIMEOUT)+1 bits and saturates, never wrapping.

Test Plan:
- m0 read at 0x100 (slave returns 0xDEADBEEF after 2 cycles), m1 idle -> s_req high 1 cycle after m0_req; m0_rdata=0xDEADBEEF with m0_ack; back to IDLE; grant=01 during the transfer.
- m0_req and m1_req both high from reset, repeated 4 transfers each -> grants alternate 0,1,0,1…, starting with 0; one idle cycle between transfers.
- m0 AMO: read 0x200 with m0_lock=1, 3 gap cycles, write 0x200 with lock=0, while m1_req is held high -> m1 gets no ack until the m0 write acks; m1 is then granted with grant=10.
- LOCK_TIMEOUT=4: m0 locks, then req=0/lock=1 indefinitely, with m1_req high -> forced release after 4 locked cycles; m1 is granted next.
- resv_valid=1, resv_addr=0x300; m1 writes 0x302 -> resv_kill pulses 1 cycle after ack. m1 writes 0x304 -> no pulse. m0 writes 0x300 -> no pulse.
- Assert rst during an m1 write with s_ack not yet returned -> all outputs 0 immediately; after release, an m0-only request is granted first.

Source files
------------

// File: rtl/dmem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_bus_arbiter
//
// Two-master, one-slave arbiter for the data-memory bus.
//   Master 0 : core MEM-stage port (driven by the atomic access controller).
//   Master 1 : secondary requester (debug / DMA).
// Grants are round-robin. A master that completes a transfer with its lock
// input high keeps the bus (LOCKEDx) so an AMO read-modify-write cannot be
// split by the other master. A locked owner that sits idle too long is
// forcibly released. Master-1 writes that hit the core's LR reservation
// word raise a one-cycle resv_kill pulse so the pending SC fails.
//
// Handshake: a master raises mx_req with its command fields and holds them
// stable until it sees mx_ack for one cycle; the transfer completes in the
// cycle where both mx_req and mx_ack are high. The slave sees the same
// contract on s_req / s_ack.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   m0_* / m1_*     master request side (req, we, addr, wdata, sel, lock in;
//                   rdata, ack out)
//   s_*             slave side (req, we, addr, wdata, sel out; rdata, ack in)
//   resv_valid/addr core LR reservation being snooped
//   resv_kill       one-cycle pulse, master 1 wrote the reserved word
//   grant           one-hot current owner {m1, m0}
// ---------------------------------------------------------------------------
module dmem_bus_arbiter #(
    parameter int LOCK_TIMEOUT = 16,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [3:0]        m0_sel,
    input  logic              m0_lock,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [3:0]        m1_sel,
    input  logic              m1_lock,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,

    output logic              s_req,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [3:0]        s_sel,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_ack,

    input  logic              resv_valid,
    input  logic [ADDR_W-1:0] resv_addr,
    output logic              resv_kill,

    output logic [1:0]        grant
);

    localparam int               CNT_W      = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((LOCK_TIMEOUT > 0) ? (LOCK_TIMEOUT - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam bit               TIMEOUT_EN = (LOCK_TIMEOUT != 0);
    // Reservation granule is one 32-bit word: ignore the byte offset bits.
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OWN0,
        ST_OWN1,
        ST_LOCKED0,
        ST_LOCKED1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_last_grant;      // 0: master 0 last owned, 1: master 1
    logic             w_last_grant_next;
    logic [CNT_W-1:0] r_lock_cnt;
    logic [CNT_W-1:0] w_lock_cnt_next;
    logic             r_resv_kill;

    logic             w_own0;
    logic             w_own1;
    logic             w_cur_req;
    logic             w_cur_lock;
    logic [ADDR_W-1:0] w_addr_diff;
    logic             w_word_hit;

    // Owner decode: the state register is the only source of the grant.
    assign w_own0     = (r_state == ST_OWN0) || (r_state == ST_LOCKED0);
    assign w_own1     = (r_state == ST_OWN1) || (r_state == ST_LOCKED1);
    assign w_cur_req  = w_own1 ? m1_req  : m0_req;
    assign w_cur_lock = w_own1 ? m1_lock : m0_lock;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;        // master 0 wins the first tie
            r_lock_cnt   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
            r_lock_cnt   <= w_lock_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        w_lock_cnt_next   = r_lock_cnt;

        case (r_state)
            ST_IDLE: begin
                if (m0_req && m1_req) begin
                    w_state_next = r_last_grant ? ST_OWN0 : ST_OWN1;
                end else if (m0_req) begin
                    w_state_next = ST_OWN0;
                end else if (m1_req) begin
                    w_state_next = ST_OWN1;
                end
            end

            ST_OWN0, ST_OWN1: begin
                if (s_ack) begin
                    w_last_grant_next = w_own1;
                    if (w_cur_lock) begin
                        w_state_next    = w_own1 ? ST_LOCKED1 : ST_LOCKED0;
                        w_lock_cnt_next = '0;
                    end else begin
                        // Unlocked transfers always pass through IDLE.
                        w_state_next = ST_IDLE;
                    end
                end else if (!w_cur_req) begin
                    // Owner abandoned its request before the ack.
                    w_state_next = ST_IDLE;
                end
            end

            ST_LOCKED0, ST_LOCKED1: begin
                if (w_cur_req) begin
                    w_lock_cnt_next = '0;
                    if (s_ack) begin
                        w_last_grant_next = w_own1;
                        if (!w_cur_lock) begin
                            w_state_next = ST_IDLE;
                        end
                    end
                end else if (!w_cur_lock) begin
                    w_state_next = ST_IDLE;
                end else if (TIMEOUT_EN && (r_lock_cnt == CNT_LAST)) begin
                    // Forced release; the owner becomes "last" so a waiting
                    // peer wins the next arbitration.
                    w_state_next      = ST_IDLE;
                    w_last_grant_next = w_own1;
                end else if (r_lock_cnt != CNT_MAX) begin
                    w_lock_cnt_next = r_lock_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus muxing: slave side follows the owner, non-owner sees zeros.
    // ------------------------------------------------------------------
    always_comb begin
        s_req    = 1'b0;
        s_we     = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_sel    = '0;
        m0_rdata = '0;
        m0_ack   = 1'b0;
        m1_rdata = '0;
        m1_ack   = 1'b0;

        if (w_own0) begin
            s_req    = m0_req;
            s_we     = m0_we;
            s_addr   = m0_addr;
            s_wdata  = m0_wdata;
            s_sel    = m0_sel;
            m0_rdata = s_rdata;
            m0_ack   = s_ack;
        end else if (w_own1) begin
            s_req    = m1_req;
            s_we     = m1_we;
            s_addr   = m1_addr;
            s_wdata  = m1_wdata;
            s_sel    = m1_sel;
            m1_rdata = s_rdata;
            m1_ack   = s_ack;
        end
    end

    assign grant = {w_own1, w_own0};

    // ------------------------------------------------------------------
    // Reservation snoop: word compare only, byte enables are ignored.
    // ------------------------------------------------------------------
    assign w_addr_diff = s_addr ^ resv_addr;
    assign w_word_hit  = ~|(w_addr_diff & WORD_MASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resv_kill <= 1'b0;
        end else begin
            r_resv_kill <= w_own1 && s_ack && s_we && resv_valid && w_word_hit;
        end
    end

    assign resv_kill = r_resv_kill;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for dmem_bus_arbiter (LOCK_TIMEOUT = 4).
// A behavioural model tracks "who owns the bus, is it held, how long has it
// been held idle, who went last" and predicts every output each cycle.
// Directed scenarios add literal expectations; a random phase follows.
// ---------------------------------------------------------------------------
module tb_dmem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          m0_req, m0_we, m0_lock, m0_ack;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic [3:0]    m0_sel;
    logic          m1_req, m1_we, m1_lock, m1_ack;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [3:0]    m1_sel;
    logic          s_req, s_we, s_ack;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [3:0]    s_sel;
    logic          resv_valid, resv_kill;
    logic [AW-1:0] resv_addr;
    logic [1:0]    grant;

    dmem_bus_arbiter #(.LOCK_TIMEOUT(TO), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_sel(m0_sel), .m0_lock(m0_lock), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_sel(m1_sel), .m1_lock(m1_lock), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_sel(s_sel), .s_rdata(s_rdata), .s_ack(s_ack),
        .resv_valid(resv_valid), .resv_addr(resv_addr), .resv_kill(resv_kill),
        .grant(grant)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: -1 none, 0 or 1; held: owner keeps bus between transfers;
    // idle_cnt: cycles a held owner has sat without a request.
    int mo       = -1;
    bit mheld    = 1'b0;
    int midle    = 0;
    int mlast    = 1;
    bit mkill    = 1'b0;

    wire m_rq = (mo == 0) ? m0_req  : (mo == 1) ? m1_req  : 1'b0;
    wire m_lk = (mo == 0) ? m0_lock : (mo == 1) ? m1_lock : 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mo    <= -1;
            mheld <= 1'b0;
            midle <= 0;
            mlast <= 1;
            mkill <= 1'b0;
        end else begin
            mkill <= (mo == 1) && s_ack && m1_we && resv_valid &&
                     (m1_addr[AW-1:2] == resv_addr[AW-1:2]);
            if (mo < 0) begin
                if (m0_req && m1_req) mo <= (mlast == 0) ? 1 : 0;
                else if (m0_req)      mo <= 0;
                else if (m1_req)      mo <= 1;
            end else if (!mheld) begin
                if (s_ack) begin
                    mlast <= mo;
                    if (m_lk) begin
                        mheld <= 1'b1;
                        midle <= 0;
                    end else begin
                        mo <= -1;
                    end
                end else if (!m_rq) begin
                    mo <= -1;
                end
            end else begin
                if (m_rq) begin
                    midle <= 0;
                    if (s_ack) begin
                        mlast <= mo;
                        if (!m_lk) begin
                            mo    <= -1;
                            mheld <= 1'b0;
                        end
                    end
                end else if (!m_lk) begin
                    mo    <= -1;
                    mheld <= 1'b0;
                end else if (midle + 1 >= TO) begin
                    mlast <= mo;
                    mo    <= -1;
                    mheld <= 1'b0;
                end else begin
                    midle <= midle + 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            begin
                logic e0, e1;
                e0 = (mo == 0);
                e1 = (mo == 1);
                chk("cyc_grant",    grant,    {e1, e0});
                chk("cyc_s_req",    s_req,    e0 ? m0_req   : e1 ? m1_req   : 1'b0);
                chk("cyc_s_we",     s_we,     e0 ? m0_we    : e1 ? m1_we    : 1'b0);
                chk("cyc_s_addr",   s_addr,   e0 ? m0_addr  : e1 ? m1_addr  : '0);
                chk("cyc_s_wdata",  s_wdata,  e0 ? m0_wdata : e1 ? m1_wdata : '0);
                chk("cyc_s_sel",    s_sel,    e0 ? m0_sel   : e1 ? m1_sel   : 4'h0);
                chk("cyc_m0_ack",   m0_ack,   e0 & s_ack);
                chk("cyc_m1_ack",   m1_ack,   e1 & s_ack);
                chk("cyc_m0_rdata", m0_rdata, e0 ? s_rdata : '0);
                chk("cyc_m1_rdata", m1_rdata, e1 ? s_rdata : '0);
                chk("cyc_kill",     resv_kill, mkill);
            end
        end
    end

    // Order in which masters completed transfers.
    int glog[$];
    initial begin
        forever begin
            @(negedge clk);
            if (m0_ack) glog.push_back(0);
            if (m1_ack) glog.push_back(1);
        end
    end

    task automatic chk_log(input string name, input int exp_q[$]);
        chk({name, "_len"}, glog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < glog.size(); i++)
            chk(name, glog[i], exp_q[i]);
    endtask

    // ---------------- slave responder ----------------
    int          sl_cnt  = 0;
    int          sl_lat  = 2;
    bit          sl_rand = 1'b0;
    logic [31:0] sl_data = 32'h0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            s_ack   = 1'b0;
            s_rdata = sl_rand ? $urandom : sl_data;
            if (!rst && s_req) begin
                if (sl_cnt >= sl_lat) begin
                    s_ack  = 1'b1;
                    sl_cnt = 0;
                    if (sl_rand) sl_lat = $urandom_range(0, 3);
                end else begin
                    sl_cnt++;
                end
            end else begin
                sl_cnt = 0;
            end
        end
    end

    // ---------------- master driver ----------------
    // Called at posedge+1; returns at posedge+1 after the ack edge.
    task automatic m_xfer(input int i, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel,
                          input bit lock, output logic [31:0] rd);
        bit got;
        if (i == 0) begin
            m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_sel = sel; m0_lock = lock; m0_req = 1'b1;
        end else begin
            m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_sel = sel; m1_lock = lock; m1_req = 1'b1;
        end
        got = 1'b0;
        rd  = '0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if ((i == 0) ? m0_ack : m1_ack) begin
                got = 1'b1;
                rd  = (i == 0) ? m0_rdata : m1_rdata;
            end
        end
        @(posedge clk);
        #1;
        if (i == 0) m0_req = 1'b0;
        else        m1_req = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL xfer_timeout m%0d: ack 0 required 1", i);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [31:0] addr_tab [4] = '{32'h300, 32'h302, 32'h304, 32'h308};
    bit rand_done = 1'b0;

    task automatic rand_master(input int i, input int n);
        logic [31:0] rdl;
        for (int k = 0; k < n; k++) begin
            int  gap;
            bit  lk;
            logic [31:0] a;
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            a  = addr_tab[$urandom_range(0, 3)];
            lk = (i == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 5) == 0);
            m_xfer(i, $urandom_range(0, 1), a, $urandom, 4'($urandom_range(1, 15)), lk, rdl);
            if (lk) begin
                gap = $urandom_range(0, 6);
                if (gap > 0) begin
                    repeat (gap) @(posedge clk);
                    #1;
                end
                m_xfer(i, 1'b1, a, $urandom, 4'hF, 1'b0, rdl);
            end
        end
    endtask

    // Reservation-snoop table: master, we, addr, sel, expected kill pulse.
    typedef struct {
        int          m;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  sel;
        bit          kill;
    } resv_case_t;

    resv_case_t resv_tab [5] = '{
        '{1, 1'b1, 32'h302, 4'hF, 1'b1},
        '{1, 1'b1, 32'h304, 4'hF, 1'b0},
        '{0, 1'b1, 32'h300, 4'hF, 1'b0},
        '{1, 1'b1, 32'h300, 4'h1, 1'b1},
        '{1, 1'b0, 32'h300, 4'hF, 1'b0}
    };

    logic [31:0] rd0, rd1;
    int          exp_alt[$];
    int          exp_amo[$];

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_sel = '0; m0_lock = 0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_sel = '0; m1_lock = 0;
        s_ack = 0; s_rdata = '0; resv_valid = 0; resv_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_req", s_req, 1'b0);
        chk("rst_kill",  resv_kill, 1'b0);
        @(posedge clk);
        #1;

        // Single m0 read
        sl_data = 32'hDEADBEEF;
        sl_lat  = 2;
        fork
            m_xfer(0, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, rd0);
            begin
                @(negedge clk);
                chk("t1_arb_cycle", grant, 2'b00);
                @(negedge clk);
                chk("t1_grant",  grant,  2'b01);
                chk("t1_s_req",  s_req,  1'b1);
                chk("t1_s_addr", s_addr, 32'h100);
            end
        join
        chk("t1_rdata", rd0, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_idle_after", grant, 2'b00);
        @(posedge clk);
        #1;

        // Round-robin with both masters busy from reset
        do_reset();
        glog.delete();
        fork
            for (int k = 0; k < 4; k++) m_xfer(0, 1'b1, 32'h10 + k, 32'hA0 + k, 4'hF, 1'b0, rd0);
            for (int k = 0; k < 4; k++) m_xfer(1, 1'b1, 32'h20 + k, 32'hB0 + k, 4'hF, 1'b0, rd1);
        join
        exp_alt = '{0, 1, 0, 1, 0, 1, 0, 1};
        chk_log("rr_order", exp_alt);

        // AMO sequence holds off master 1
        glog.delete();
        fork
            begin
                m_xfer(0, 1'b0, 32'h200, 32'h0, 4'hF, 1'b1, rd0);
                repeat (3) @(posedge clk);
                #1;
                m_xfer(0, 1'b1, 32'h200, 32'h55, 4'hF, 1'b0, rd0);
                @(negedge clk);
                chk("amo_idle_gap", grant, 2'b00);
                @(negedge clk);
                chk("amo_m1_grant", grant, 2'b10);
            end
            m_xfer(1, 1'b0, 32'h400, 32'h0, 4'hF, 1'b0, rd1);
        join
        exp_amo = '{0, 0, 1};
        chk_log("amo_order", exp_amo);

        // Lock timeout with master 1 waiting
        m_xfer(0, 1'b0, 32'h700, 32'h0, 4'hF, 1'b1, rd0);
        fork
            m_xfer(1, 1'b0, 32'h704, 32'h0, 4'hF, 1'b0, rd1);
            begin
                for (int k = 0; k < TO; k++) begin
                    @(negedge clk);
                    chk("to_held", grant, 2'b01);
                end
                @(negedge clk);
                chk("to_release", grant, 2'b00);
                @(negedge clk);
                chk("to_m1_grant", grant, 2'b10);
            end
        join
        m0_lock = 1'b0;

        // Reservation snoop
        resv_valid = 1'b1;
        resv_addr  = 32'h300;
        for (int k = 0; k < 5; k++) begin
            m_xfer(resv_tab[k].m, resv_tab[k].we, resv_tab[k].addr, 32'h1234, resv_tab[k].sel, 1'b0, rd0);
            @(negedge clk);
            chk($sformatf("resv_kill_%0d", k), resv_kill, resv_tab[k].kill);
            @(negedge clk);
            chk($sformatf("resv_kill_end_%0d", k), resv_kill, 1'b0);
            @(posedge clk);
            #1;
        end
        resv_valid = 1'b0;

        // Reset in the middle of a master-1 write
        sl_lat = 10;
        m1_we = 1'b1; m1_addr = 32'h500; m1_wdata = 32'hCAFE; m1_sel = 4'hF; m1_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_pre_grant", grant, 2'b10);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_s_req",    s_req,    1'b0);
        chk("mid_s_we",     s_we,     1'b0);
        chk("mid_s_addr",   s_addr,   32'h0);
        chk("mid_s_wdata",  s_wdata,  32'h0);
        chk("mid_s_sel",    s_sel,    4'h0);
        chk("mid_grant",    grant,    2'b00);
        chk("mid_m1_ack",   m1_ack,   1'b0);
        chk("mid_m1_rdata", m1_rdata, 32'h0);
        chk("mid_kill",     resv_kill, 1'b0);
        m1_req = 1'b0;
        m1_we  = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        sl_lat = 2;
        fork
            m_xfer(0, 1'b0, 32'h600, 32'h0, 4'hF, 1'b0, rd0);
            begin
                @(negedge clk);
                @(negedge clk);
                chk("post_rst_grant", grant, 2'b01);
            end
        join

        // Random traffic
        sl_rand = 1'b1;
        fork
            begin
                fork
                    rand_master(0, 40);
                    rand_master(1, 40);
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    resv_valid = $urandom_range(0, 1);
                    resv_addr  = ($urandom_range(0, 1) == 0) ? 32'h300 : 32'h304;
                end
            end
        join

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
